// File: rtl/rv32_pkg.sv
// RV32I opcode constants, decoded-instruction record and the shared decode function.
// Latency: none; purely combinational helpers for other stages to reuse.
// Backpressure: not applicable; no handshake lives in this package.
package rv32;

    typedef logic [31:0] rv32_inst_t;

    localparam logic [6:0] RV32_OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] RV32_OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] RV32_OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0] RV32_OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] RV32_OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] RV32_OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] RV32_OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] RV32_OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] RV32_OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] RV32_OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] RV32_OPCODE_SYSTEM   = 7'b1110011;

    localparam logic [6:0] RV32_FUNCT7_ZERO = 7'b0000000;
    localparam logic [6:0] RV32_FUNCT7_ALT  = 7'b0100000;

    typedef struct packed {
        rv32_inst_t  inst;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [11:0] funct12;
        logic [31:0] imm;
        logic        decode_error;
    } rv32_fields_t;

    // Raw fields are always extracted; the opcode only picks the immediate
    // layout and which funct encodings count as legal.
    function automatic rv32_fields_t rv32_decode(input rv32_inst_t inst);
        rv32_fields_t f;
        logic         err;
        f              = '0;
        f.inst         = inst;
        f.opcode       = inst[6:0];
        f.rd           = inst[11:7];
        f.funct3       = inst[14:12];
        f.rs1          = inst[19:15];
        f.rs2          = inst[24:20];
        f.funct7       = inst[31:25];
        f.funct12      = inst[31:20];
        err            = (inst[1:0] != 2'b11);
        case (f.opcode)
            RV32_OPCODE_LUI, RV32_OPCODE_AUIPC:
                f.imm = {inst[31:12], 12'b0};
            RV32_OPCODE_JAL:
                f.imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
            RV32_OPCODE_JALR: begin
                f.imm = {{20{inst[31]}}, inst[31:20]};
                err   = err | (f.funct3 != 3'b000);
            end
            RV32_OPCODE_BRANCH: begin
                f.imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                err   = err | (f.funct3 == 3'b010) | (f.funct3 == 3'b011);
            end
            RV32_OPCODE_LOAD: begin
                f.imm = {{20{inst[31]}}, inst[31:20]};
                err   = err | (f.funct3 == 3'b011) | (f.funct3 == 3'b110) | (f.funct3 == 3'b111);
            end
            RV32_OPCODE_STORE: begin
                f.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                err   = err | (f.funct3 > 3'b010);
            end
            RV32_OPCODE_OP_IMM: begin
                f.imm = {{20{inst[31]}}, inst[31:20]};
                // Shift-immediates reuse funct7 as an encoding qualifier.
                if (f.funct3 == 3'b001)
                    err = err | (f.funct7 != RV32_FUNCT7_ZERO);
                else if (f.funct3 == 3'b101)
                    err = err | ((f.funct7 != RV32_FUNCT7_ZERO) && (f.funct7 != RV32_FUNCT7_ALT));
            end
            RV32_OPCODE_OP: begin
                if (f.funct7 == RV32_FUNCT7_ALT)
                    err = err | ((f.funct3 != 3'b000) && (f.funct3 != 3'b101));
                else
                    err = err | (f.funct7 != RV32_FUNCT7_ZERO);
            end
            RV32_OPCODE_MISC_MEM, RV32_OPCODE_SYSTEM:
                f.imm = {{20{inst[31]}}, inst[31:20]};
            default:
                err = 1'b1;
        endcase
        f.decode_error = err;
        return f;
    endfunction

endpackage

// File: rtl/rv32_skid_buffer.sv
// Two-entry valid/ready register slice: main output register plus one skid register.
// Latency: 1 cycle accept-to-output; full throughput with out_ready high.
// Backpressure: in_ready is registered (!skid full), no combinational path from out_ready.
module rv32_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_dat
);

    logic             main_vld_q, main_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] main_dat_q, main_dat_d;
    logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
    logic             accept;
    logic             drain;

    assign in_ready  = !skid_vld_q;
    assign out_valid = main_vld_q;
    assign out_dat   = main_dat_q;
    assign accept    = in_valid && !skid_vld_q;
    assign drain     = main_vld_q && out_ready;

    // Next-state: flush wins; a free or draining main register is refilled from skid first, then input.
    always_comb begin
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        main_dat_d = main_dat_q;
        skid_dat_d = skid_dat_q;
        if (flush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || drain) begin
            if (skid_vld_q) begin
                // Skid full implies in_ready low, so no accept can collide here.
                main_vld_d = 1'b1;
                main_dat_d = skid_dat_q;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_vld_d = 1'b1;
                main_dat_d = in_dat;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_vld_d = 1'b1;
            skid_dat_d = in_dat;
        end
    end

    // State registers; reset also clears the payload so outputs read zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            main_dat_q <= '0;
            skid_dat_q <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            main_dat_q <= main_dat_d;
            skid_dat_q <= skid_dat_d;
        end
    end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32I decode stage: decodes fetch words into rv32_fields_t and registers them with the PC.
// Latency: 1 cycle accept-to-out_valid; one instruction per cycle sustained.
// Backpressure: two-entry skid; in_ready drops only while the skid register is occupied.
module rv32_decode_stage
    import rv32::*;
#(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_inst,
    input  logic [PC_WIDTH-1:0] in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output rv32_fields_t        out_fields,
    output logic [PC_WIDTH-1:0] out_pc
);

    localparam int PAYLOAD_W = $bits(rv32_fields_t) + PC_WIDTH;

    rv32_fields_t         dec_fields;
    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;

    assign dec_fields = rv32_decode(in_inst);
    assign in_payload = {dec_fields, in_pc};
    assign {out_fields, out_pc} = out_payload;

    rv32_skid_buffer #(
        .WIDTH (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dat    (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_dat   (out_payload)
    );

endmodule

// File: tb/tb_rv32_decode_stage.sv
module tb_rv32_decode_stage;
    import rv32::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_inst;
    logic [31:0]  in_pc;
    logic         out_valid;
    logic         out_ready;
    rv32_fields_t out_fields;
    logic [31:0]  out_pc;

    int total = 0;
    int bad   = 0;
    int delivered = 0;
    bit mon_en = 1'b0;

    typedef struct {
        rv32_fields_t f;
        logic [31:0]  pc;
    } exp_t;
    exp_t sb[$];

    bit           stall_q = 1'b0;
    rv32_fields_t held_f;
    logic [31:0]  held_pc;

    always #5 clk = ~clk;

    rv32_decode_stage #(.PC_WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_inst    (in_inst),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_fields (out_fields),
        .out_pc     (out_pc)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Independent reference decode, written from the instruction-format tables.
    function automatic rv32_fields_t ref_decode(input logic [31:0] w);
        rv32_fields_t f;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12];
        f7 = w[31:25];
        f = '0;
        f.inst = w; f.opcode = w[6:0]; f.rd = w[11:7]; f.funct3 = f3;
        f.rs1 = w[19:15]; f.rs2 = w[24:20]; f.funct7 = f7; f.funct12 = w[31:20];
        f.decode_error = (w[1:0] != 2'b11);
        case (w[6:0])
            7'h37, 7'h17: f.imm = {w[31:12], 12'h000};
            7'h6F: f.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
            7'h67: begin f.imm = {{20{w[31]}}, w[31:20]}; if (f3 != 0) f.decode_error = 1; end
            7'h63: begin
                f.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
                if (f3 == 2 || f3 == 3) f.decode_error = 1;
            end
            7'h03: begin
                f.imm = {{20{w[31]}}, w[31:20]};
                if (f3 == 3 || f3 == 6 || f3 == 7) f.decode_error = 1;
            end
            7'h23: begin f.imm = {{20{w[31]}}, w[31:25], w[11:7]}; if (f3 > 2) f.decode_error = 1; end
            7'h13: begin
                f.imm = {{20{w[31]}}, w[31:20]};
                if (f3 == 1 && f7 != 0) f.decode_error = 1;
                if (f3 == 5 && !(f7 == 0 || f7 == 7'h20)) f.decode_error = 1;
            end
            7'h33: begin
                if (f7 == 7'h20) begin
                    if (!(f3 == 0 || f3 == 5)) f.decode_error = 1;
                end else if (f7 != 0) f.decode_error = 1;
            end
            7'h0F, 7'h73: f.imm = {{20{w[31]}}, w[31:20]};
            default: f.decode_error = 1;
        endcase
        return f;
    endfunction

    // Scoreboard monitor: occupancy model, hold-stability, in-order delivery.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready_vs_occ", in_ready, sb.size() < 2);
            chk("out_valid_vs_occ", out_valid, sb.size() != 0);
            if (stall_q) begin
                chk("hold_fields", out_fields, held_f);
                chk("hold_pc", out_pc, held_pc);
            end
            stall_q = out_valid && !out_ready && rst && !flush;
            held_f  = out_fields;
            held_pc = out_pc;
            if (!rst || flush) begin
                sb.delete();
            end else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("sb_pc", out_pc, e.pc);
                        chk("sb_fields", out_fields, e.f);
                        delivered++;
                    end
                end
                if (in_valid && in_ready) begin
                    exp_t n;
                    n.f  = ref_decode(in_inst);
                    n.pc = in_pc;
                    sb.push_back(n);
                end
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
    task automatic send(input logic [31:0] pc, input logic [31:0] w);
        int n;
        bit ok;
        n = 0;
        ok = 0;
        in_valid = 1'b1;
        in_inst  = w;
        in_pc    = pc;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1;
            else n++;
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic directed(input string tag, input logic [31:0] pc, input logic [31:0] w,
                            output rv32_fields_t f);
        send(pc, w);
        @(negedge clk);
        chk({tag, "_latency"}, out_valid, 1);
        chk({tag, "_pc"}, out_pc, pc);
        f = out_fields;
        @(posedge clk); #1;
    endtask

    initial begin
        rv32_fields_t f;
        int base;
        bit done;
        int n;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_fields", out_fields, 0);
        chk("rst_out_pc", out_pc, 0);
        mon_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;

        // Directed decodes
        out_ready = 1'b1;
        directed("addi", 32'h100, 32'hFFF00093, f);
        chk("addi_opcode", f.opcode, 7'h13);
        chk("addi_rd", f.rd, 1);
        chk("addi_rs1", f.rs1, 0);
        chk("addi_f3", f.funct3, 0);
        chk("addi_imm", f.imm, 32'hFFFFFFFF);
        chk("addi_err", f.decode_error, 0);
        directed("sw", 32'h104, 32'h0020A423, f);
        chk("sw_imm", f.imm, 32'h00000008);
        chk("sw_rs1", f.rs1, 1);
        chk("sw_rs2", f.rs2, 2);
        chk("sw_f3", f.funct3, 3'b010);
        chk("sw_err", f.decode_error, 0);
        directed("jal", 32'h108, 32'hFFDFF06F, f);
        chk("jal_imm", f.imm, 32'hFFFFFFFC);
        directed("lui", 32'h10C, 32'h123452B7, f);
        chk("lui_imm", f.imm, 32'h12345000);
        chk("lui_rd", f.rd, 5);
        directed("ill0", 32'h110, 32'h00000000, f);
        chk("ill0_err", f.decode_error, 1);
        directed("illF", 32'h114, 32'hFFFFFFFF, f);
        chk("illF_err", f.decode_error, 1);
        directed("illop", 32'h118, 32'h40001033, f);
        chk("illop_err", f.decode_error, 1);

        // Random backpressure stream of 8 sequential PCs
        base = delivered;
        done = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(32'h2000 + 32'(4 * i), $urandom());
                done = 1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
        chk("stream_drained", sb.size(), 0);
        chk("stream_count", delivered - base, 8);

        // Flush with main+skid full and a concurrent in_valid
        out_ready = 1'b0;
        send(32'h3000, 32'h00100093);
        send(32'h3004, 32'h00200113);
        in_valid = 1'b1; in_inst = 32'h00300193; in_pc = 32'h3008; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        // Flush while an instruction is accepted into an empty stage
        @(posedge clk); #1;
        in_valid = 1'b1; in_inst = 32'h00400213; in_pc = 32'h300C; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        base = delivered;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("flush_none_seen", delivered, base);

        // Reset mid-stream
        out_ready = 1'b0;
        send(32'h4000, 32'h00500293);
        send(32'h4004, 32'h00600313);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 1);
        chk("mrst_out_fields", out_fields, 0);
        chk("mrst_out_pc", out_pc, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        directed("post_rst", 32'h5000, 32'h00700393, f);
        chk("post_rst_rd", f.rd, 7);
        chk("post_rst_imm", f.imm, 7);

        repeat (3) @(posedge clk);
        #1;
        chk("final_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
